// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, forwarding selects and ALU operation codes for the pipeline.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, hazard/forwarding inputs and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
);
  logic              Stall, Flush, IdValid;
  logic [2:0]        IdALUControl;
  logic              IdALUSrc, IdRegWrite, IdMemWrite, IdMemToReg, IdBranch;
  logic [DATA_W-1:0] IdRD1, IdRD2, IdImmExt;
  logic [REG_AW-1:0] IdRs, IdRt, IdWriteReg;
  logic              MemRegWrite, WbRegWrite;
  logic [REG_AW-1:0] MemWriteReg, WbWriteReg;
  logic [DATA_W-1:0] MemALUResult, WbResult;
  logic              ExValid;
  logic [2:0]        ALUControl;
  logic [DATA_W-1:0] SrcA, SrcB, ExWriteData;
  logic [REG_AW-1:0] ExWriteReg;
  logic              ExRegWrite, ExMemWrite, ExMemToReg, ExBranch;
  logic [1:0]        ForwardA, ForwardB;
  modport master (
    output Stall, Flush, IdValid, IdALUControl, IdALUSrc, IdRegWrite, IdMemWrite, IdMemToReg,
           IdBranch, IdRD1, IdRD2, IdImmExt, IdRs, IdRt, IdWriteReg,
           MemRegWrite, MemWriteReg, MemALUResult, WbRegWrite, WbWriteReg, WbResult,
    input  ExValid, ALUControl, SrcA, SrcB, ExWriteData, ExWriteReg,
           ExRegWrite, ExMemWrite, ExMemToReg, ExBranch, ForwardA, ForwardB
  );
  modport slave (
    input  Stall, Flush, IdValid, IdALUControl, IdALUSrc, IdRegWrite, IdMemWrite, IdMemToReg,
           IdBranch, IdRD1, IdRD2, IdImmExt, IdRs, IdRt, IdWriteReg,
           MemRegWrite, MemWriteReg, MemALUResult, WbRegWrite, WbWriteReg, WbResult,
    output ExValid, ALUControl, SrcA, SrcB, ExWriteData, ExWriteReg,
           ExRegWrite, ExMemWrite, ExMemToReg, ExBranch, ForwardA, ForwardB
  );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: picks one ALU operand from EX/MEM, MEM/WB or the held register value.
module fwd_select #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_held,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_write_reg,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_write_reg,
  input  logic [DATA_W-1:0] i_wb_result,
  output logic [DATA_W-1:0] o_value,
  output logic [1:0]        o_sel
);
  import pipe_pkg::*;
  logic w_mem_hit, w_wb_hit;
  // r0 is hardwired zero, so a write to it never forwards
  always_comb begin
    w_mem_hit = i_valid && i_mem_reg_write && (i_mem_write_reg == i_src) && (i_src != '0);
    w_wb_hit  = i_valid && i_wb_reg_write && (i_wb_write_reg == i_src) && (i_src != '0);
    o_sel     = w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : FWD_NONE;
    o_value   = w_mem_hit ? i_mem_result : w_wb_hit ? i_wb_result : i_held;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush, stall-hold and operand forwarding into the ALU.
module id_ex_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  import pipe_pkg::*;
  logic              r_valid, r_alu_src, r_reg_write, r_mem_write, r_mem_to_reg, r_branch;
  alu_op_e           r_alu_ctrl;
  logic [REG_AW-1:0] r_rs, r_rt, r_write_reg;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b;
  logic [1:0]        w_sel_a, w_sel_b;
  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .i_valid(r_valid), .i_src(r_rs), .i_held(r_rd1),
    .i_mem_reg_write(bus.MemRegWrite), .i_mem_write_reg(bus.MemWriteReg), .i_mem_result(bus.MemALUResult),
    .i_wb_reg_write(bus.WbRegWrite), .i_wb_write_reg(bus.WbWriteReg), .i_wb_result(bus.WbResult),
    .o_value(w_fwd_a), .o_sel(w_sel_a)
  );
  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .i_valid(r_valid), .i_src(r_rt), .i_held(r_rd2),
    .i_mem_reg_write(bus.MemRegWrite), .i_mem_write_reg(bus.MemWriteReg), .i_mem_result(bus.MemALUResult),
    .i_wb_reg_write(bus.WbRegWrite), .i_wb_write_reg(bus.WbWriteReg), .i_wb_result(bus.WbResult),
    .o_value(w_fwd_b), .o_sel(w_sel_b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.Flush) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= ALU_ADD;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_write_reg  <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
    end else if (bus.Stall) begin
      // latch forwarded operands so a producer retiring mid-stall is not lost
      if (r_valid) begin
        r_rd1 <= w_fwd_a;
        r_rd2 <= w_fwd_b;
      end
    end else begin
      r_valid      <= bus.IdValid;
      r_alu_ctrl   <= alu_op_e'(bus.IdALUControl);
      r_alu_src    <= bus.IdALUSrc;
      r_reg_write  <= bus.IdValid & bus.IdRegWrite;
      r_mem_write  <= bus.IdValid & bus.IdMemWrite;
      r_mem_to_reg <= bus.IdValid & bus.IdMemToReg;
      r_branch     <= bus.IdValid & bus.IdBranch;
      r_write_reg  <= bus.IdWriteReg;
      r_rs         <= bus.IdRs;
      r_rt         <= bus.IdRt;
      r_rd1        <= bus.IdRD1;
      r_rd2        <= bus.IdRD2;
      r_imm        <= bus.IdImmExt;
    end
  end
  assign bus.ExValid     = r_valid;
  assign bus.ALUControl  = r_alu_ctrl;
  assign bus.SrcA        = w_fwd_a;
  assign bus.SrcB        = r_alu_src ? r_imm : w_fwd_b;
  assign bus.ExWriteData = w_fwd_b;
  assign bus.ExWriteReg  = r_write_reg;
  assign bus.ExRegWrite  = r_reg_write;
  assign bus.ExMemWrite  = r_mem_write;
  assign bus.ExMemToReg  = r_mem_to_reg;
  assign bus.ExBranch    = r_branch;
  assign bus.ForwardA    = w_sel_a;
  assign bus.ForwardB    = w_sel_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand-written reset, stall-refresh and flush sequences.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        v;
    logic [2:0]  alu;
    logic        asrc;
    logic [4:0]  rs, rt;
    logic [31:0] rd1, rd2, imm;
    logic        mrw;
    logic [4:0]  mreg;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wreg;
    logic [31:0] wres;
    logic [31:0] ea, eb, ewd;
    logic [1:0]  efa, efb;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_id(input logic v, input logic [2:0] alu, input logic asrc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm);
    bus.IdValid = v; bus.IdALUControl = alu; bus.IdALUSrc = asrc;
    bus.IdRegWrite = 1'b1; bus.IdMemWrite = 1'b1; bus.IdMemToReg = 1'b0; bus.IdBranch = 1'b0;
    bus.IdRs = rs; bus.IdRt = rt; bus.IdWriteReg = 5'd10;
    bus.IdRD1 = rd1; bus.IdRD2 = rd2; bus.IdImmExt = imm;
  endtask

  task automatic hz(input logic mrw, input logic [4:0] mreg, input logic [31:0] mres,
                    input logic wrw, input logic [4:0] wreg, input logic [31:0] wres);
    bus.MemRegWrite = mrw; bus.MemWriteReg = mreg; bus.MemALUResult = mres;
    bus.WbRegWrite = wrw; bus.WbWriteReg = wreg; bus.WbResult = wres;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         v  alu     asrc rs     rt     rd1           rd2           imm           mrw  mreg   mres         wrw  wreg   wres         ea            eb            ewd           efa    efb
    vecs[0] = '{1, 3'b001, 0, 5'd1, 5'd2, 32'h5,        32'h7,        32'h0,        0, 5'd0, 32'h0,      0, 5'd0, 32'h0,      32'h5,        32'h7,        32'h7,        2'b00, 2'b00};
    vecs[1] = '{1, 3'b000, 0, 5'd3, 5'd5, 32'h11,       32'h22,       32'h0,        1, 5'd3, 32'h10,     1, 5'd3, 32'h20,     32'h10,       32'h22,       32'h22,       2'b10, 2'b00};
    vecs[2] = '{1, 3'b010, 0, 5'd6, 5'd7, 32'h1,        32'h2,        32'h0,        0, 5'd6, 32'h30,     1, 5'd7, 32'h40,     32'h1,        32'h40,       32'h40,       2'b00, 2'b01};
    vecs[3] = '{1, 3'b011, 0, 5'd0, 5'd0, 32'hA,        32'hB,        32'h0,        1, 5'd0, 32'h50,     1, 5'd0, 32'h60,     32'hA,        32'hB,        32'hB,        2'b00, 2'b00};
    vecs[4] = '{1, 3'b101, 1, 5'd8, 5'd9, 32'h3,        32'h4,        32'hFFFFFFF0, 1, 5'd9, 32'h77,     0, 5'd0, 32'h0,      32'h3,        32'hFFFFFFF0, 32'h77,       2'b00, 2'b10};
    vecs[5] = '{0, 3'b000, 0, 5'd3, 5'd4, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,        1, 5'd3, 32'h10,     1, 5'd4, 32'h20,     32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 2'b00};
    bus.Stall = 1'b0; bus.Flush = 1'b0;
    load_id(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, bus.ExValid}, 32'h0);
    chk("reset_srca", bus.SrcA, 32'h0);
    chk("reset_wdata", bus.ExWriteData, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_id(vecs[i].v, vecs[i].alu, vecs[i].asrc, vecs[i].rs, vecs[i].rt, vecs[i].rd1, vecs[i].rd2, vecs[i].imm);
      hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      hz(vecs[i].mrw, vecs[i].mreg, vecs[i].mres, vecs[i].wrw, vecs[i].wreg, vecs[i].wres);
      #1;
      chk($sformatf("v%0d_srca", i), bus.SrcA, vecs[i].ea);
      chk($sformatf("v%0d_srcb", i), bus.SrcB, vecs[i].eb);
      chk($sformatf("v%0d_wdata", i), bus.ExWriteData, vecs[i].ewd);
      chk($sformatf("v%0d_fwda", i), {30'b0, bus.ForwardA}, {30'b0, vecs[i].efa});
      chk($sformatf("v%0d_fwdb", i), {30'b0, bus.ForwardB}, {30'b0, vecs[i].efb});
      chk($sformatf("v%0d_valid", i), {31'b0, bus.ExValid}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d_regwrite", i), {31'b0, bus.ExRegWrite}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d_aluctl", i), {29'b0, bus.ALUControl}, {29'b0, vecs[i].alu});
      chk($sformatf("v%0d_wreg", i), {27'b0, bus.ExWriteReg}, 32'd10);
    end

    // asynchronous reset in mid-cycle
    @(negedge clk);
    load_id(1'b1, 3'b001, 1'b0, 5'd1, 5'd2, 32'h5, 32'h7, 32'h0);
    hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'b0, bus.ExValid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.ExValid}, 32'h0);
    chk("async_rst_regwrite", {31'b0, bus.ExRegWrite}, 32'h0);
    chk("async_rst_aluctl", {29'b0, bus.ALUControl}, 32'h0);
    chk("async_rst_srca", bus.SrcA, 32'h0);
    chk("async_rst_srcb", bus.SrcB, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // stall with a WB producer of r4 retiring during the first stall cycle
    load_id(1'b1, 3'b000, 1'b1, 5'd1, 5'd4, 32'h5, 32'h6, 32'h8);
    @(posedge clk);
    @(negedge clk);
    bus.Stall = 1'b1;
    load_id(1'b1, 3'b010, 1'b0, 5'd2, 5'd3, 32'hBAD, 32'hBAD, 32'hBAD);
    hz(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h99);
    #1;
    chk("stall1_srcb", bus.SrcB, 32'h8);
    chk("stall1_wdata", bus.ExWriteData, 32'h99);
    chk("stall1_fwdb", {30'b0, bus.ForwardB}, 32'h1);
    @(negedge clk);
    hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("stall2_wdata", bus.ExWriteData, 32'h99);
    chk("stall2_fwdb", {30'b0, bus.ForwardB}, 32'h0);
    chk("stall2_srca", bus.SrcA, 32'h5);
    @(negedge clk);
    bus.Stall = 1'b0;
    #1;
    chk("release_wdata", bus.ExWriteData, 32'h99);
    chk("release_srcb", bus.SrcB, 32'h8);
    chk("release_aluctl", {29'b0, bus.ALUControl}, 32'h0);

    // flush wins over stall on the same edge
    @(negedge clk);
    bus.Stall = 1'b1; bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid", {31'b0, bus.ExValid}, 32'h0);
    chk("flush_regwrite", {31'b0, bus.ExRegWrite}, 32'h0);
    chk("flush_memwrite", {31'b0, bus.ExMemWrite}, 32'h0);
    @(negedge clk);
    bus.Stall = 1'b0; bus.Flush = 1'b0;
    load_id(1'b1, 3'b011, 1'b0, 5'd2, 5'd3, 32'h42, 32'h43, 32'h0);
    @(posedge clk);
    #1;
    chk("after_flush_valid", {31'b0, bus.ExValid}, 32'h1);
    chk("after_flush_srca", bus.SrcA, 32'h42);
    chk("after_flush_memwrite", {31'b0, bus.ExMemWrite}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage core, directly upstream of the ALU.
- Captures decoded operands and control from ID and holds them under stall.
- Turns flushed slots into bubbles.
- Resolves EX/MEM and MEM/WB forwarding, driving SrcA, SrcB and ALUControl straight into the ALU.

Parameters:
- DATA_W, 32, operand and result width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hold the stage contents (hazard unit).
- Flush  in  1  replace the stage contents with a bubble (branch taken).
- IdValid  in  1  the ID slot holds a real instruction.
- IdALUControl  in  3  ALU operation.
- IdALUSrc  in  1  1 = SrcB takes the immediate.
- IdRegWrite, IdMemWrite, IdMemToReg, IdBranch  in  1 each  control bits.
- IdRD1, IdRD2  in  DATA_W  register-file read data.
- IdImmExt  in  DATA_W  sign-extended immediate.
- IdRs, IdRt, IdWriteReg  in  REG_AW  source and destination register numbers.
- MemRegWrite  in  1  the EX/MEM instruction writes a register.
- MemWriteReg  in  REG_AW  EX/MEM destination register.
- MemALUResult  in  DATA_W  EX/MEM result.
- WbRegWrite  in  1  the MEM/WB instruction writes a register.
- WbWriteReg  in  REG_AW  MEM/WB destination register.
- WbResult  in  DATA_W  MEM/WB result.
- ExValid  out  1  the stage holds a real instruction.
- ALUControl  out  3  to the ALU.
- SrcA, SrcB  out  DATA_W  to the ALU (combinational from the held state plus forwarding inputs).
- ExWriteData  out  DATA_W  forwarded rt value, used as store data.
- ExWriteReg  out  REG_AW  destination register.
- ExRegWrite, ExMemWrite, ExMemToReg, ExBranch  out  1 each  held control bits.
- ForwardA, ForwardB  out  2  selected forwarding source (debug/verification).

Behaviour:

Reset
- rst_n low clears every register immediately (asynchronous): ExValid, all control bits, ALUControl, ExWriteReg, held RD1/RD2/Imm/Rs/Rt = 0.
- With the held state at 0 and forwarding inactive, SrcA, SrcB and ExWriteData read 0.
- Deasserting reset mid-stream simply starts from this bubble.

Capture, priority per rising edge is Flush > Stall > load
- Flush: ExValid = 0, all control bits = 0, ALUControl = 3'b000; data registers don't-care, implementation clears them.
- Stall (and no Flush): hold all control fields; perform the operand refresh below.
- Otherwise: load every Id* field. ExValid = IdValid. If IdValid = 0, control bits load as 0.

Latency
- Id* values appear on the Ex*/ALU outputs one cycle after the loading edge.

Forwarding (combinational, evaluated per operand X in {A: Rs, B: Rt})
- MEM hit: MemRegWrite and MemWriteReg == src and src != 0 → select MemALUResult, Forward = 2'b10.
- Else WB hit: WbRegWrite and WbWriteReg == src and src != 0 → select WbResult, Forward = 2'b01.
- Else select the held RD value, Forward = 2'b00.
- MEM has priority over WB when both match.
- Forwarding is suppressed (Forward = 00) when ExValid = 0.

Operand outputs
- SrcA = forwarded A.
- ExWriteData = forwarded B.
- SrcB = held Imm when ALUSrc = 1, else forwarded B.

Operand refresh
- On a Stall edge with ExValid = 1, held RD1 <= forwarded A and held RD2 <= forwarded B.
- This prevents a producer that retires during the stall from being lost.

Widths
- No arithmetic is done here; all data paths are DATA_W bits with no truncation.

Decomposition:
- Package pipe_pkg holds:
  - FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - ALU codes ADD = 000, SUB = 001, AND = 010, OR = 011, SLT = 101.
  - DATA_W and REG_AW defaults.
- One combinational sub-module, fwd_select, instantiated twice (A and B).
  - Inputs: src, held value, Mem/Wb write info, ExValid.
  - Outputs: value and 2-bit select.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with ExValid = 1 → ExValid, ExRegWrite and ALUControl are 0 immediately, before any clock edge; SrcA = SrcB = 0.
- Plain load: IdRD1 = 5, IdRD2 = 7, ALUControl = 001, ALUSrc = 0, no hazards → next cycle SrcA = 5, SrcB = 7, ForwardA = ForwardB = 00.
- Dual match: Rs = 3, MemWriteReg = 3 (MemALUResult = 0x10), WbWriteReg = 3 (WbResult = 0x20), both RegWrite = 1 → SrcA = 0x10, ForwardA = 10.
- Register 0: Rs = Rt = 0 with MemWriteReg = 0, MemRegWrite = 1 → no forwarding, SrcA = SrcB = held value.
- Stall refresh: Stall = 1 for 2 cycles; WB writes r4 = 0x99 (Rt = 4, ALUSrc = 1, Imm = 8) in stall cycle 1 only → SrcB = 8, and after release ExWriteData = 0x99.
- Flush over stall: Stall = 1 and Flush = 1 on the same edge → ExValid = 0, ExRegWrite = 0, ExMemWrite = 0; the next non-stalled edge loads new ID contents.
